// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Multi-cycle MIPS32 multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU use a radix-2 shift-add multiplier (one bit per cycle).
//   DIV/DIVU use a restoring divider (one quotient bit per cycle).
//   A launched operation keeps busy high for 33 cycles: 32 iterations plus
//   one FIN cycle that applies signs and writes HI/LO.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   -> divider datapath, DIV state and div_zero flag are built in
//   undefined -> divide starts are ignored, div_zero is tied low
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     launch operation (sampled only when idle)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val    multiplicand / dividend
//   rt_val    multiplier / divisor
//   mthi      write wdata to HI (idle only)
//   mtlo      write wdata to LO (idle only)
//   wdata     MTHI/MTLO data
//   busy      operation in progress
//   done      one-cycle pulse when an operation has written HI/LO
//   div_zero  pulses with done when the divisor was zero
//   hi, lo    architectural HI/LO registers
module muldiv_hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] FIN  = 2'd3;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif

  logic [1:0]  state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] opnd_reg;      // multiplicand magnitude, or divisor magnitude
  logic [63:0] prod_reg;      // {accumulator, remaining multiplier bits}
  logic        neg_res_reg;   // operand signs differ (signed ops only)
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic        accept_mul;
  logic [32:0] mul_sum;
  logic [63:0] mul_res;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  // Unsigned ops take raw values, so 0x80000000 stays 0x80000000.
  assign signed_op  = ~op[0];
  assign rs_neg     = signed_op & rs_val[31];
  assign rt_neg     = signed_op & rt_val[31];
  assign rs_mag     = rs_neg ? (32'd0 - rs_val) : rs_val;
  assign rt_mag     = rt_neg ? (32'd0 - rt_val) : rt_val;
  assign accept_mul = start & ~op[1];

  // Add the multiplicand into the upper half when the current multiplier
  // bit is set, then shift the whole 65-bit value right by one.
  assign mul_sum = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign mul_res = neg_res_reg ? (64'd0 - prod_reg) : prod_reg;

`ifdef MULDIV_DIV_EN
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;       // dividend bits shift out as quotient bits shift in
  logic [31:0] dividend_reg;  // raw dividend, returned in HI on divide by zero
  logic        neg_rem_reg;
  logic        dz_reg;
  logic        is_div_reg;
  logic        div_zero_reg;
  logic        accept_div;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_next;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign accept_div = start & op[1];
  // 33-bit partial remainder; the subtraction result always fits in 32 bits
  // when it is kept, so a 32-bit wrap-around subtract is exact.
  assign div_shift  = {rem_reg, quo_reg[31]};
  assign div_ge     = div_shift >= {1'b0, opnd_reg};
  assign rem_next   = div_ge ? (div_shift[31:0] - opnd_reg) : div_shift[31:0];
  assign quo_res    = neg_res_reg ? (32'd0 - quo_reg) : quo_reg;
  assign rem_res    = neg_rem_reg ? (32'd0 - rem_reg) : rem_reg;

  always_comb begin
    fin_hi = mul_res[63:32];
    fin_lo = mul_res[31:0];
    if (is_div_reg) begin
      if (dz_reg) begin
        fin_hi = dividend_reg;
        fin_lo = 32'hFFFF_FFFF;
      end else begin
        fin_hi = rem_res;
        fin_lo = quo_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg      <= '0;
      quo_reg      <= '0;
      dividend_reg <= '0;
      neg_rem_reg  <= 1'b0;
      dz_reg       <= 1'b0;
      is_div_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      div_zero_reg <= 1'b0;
      if (state_reg == IDLE && accept_div) begin
        quo_reg      <= rs_mag;
        rem_reg      <= '0;
        neg_rem_reg  <= rs_neg;
        dz_reg       <= (rt_val == 32'd0);
        dividend_reg <= rs_val;
        is_div_reg   <= 1'b1;
      end else if (state_reg == IDLE && accept_mul) begin
        is_div_reg   <= 1'b0;
      end else if (state_reg == DIV) begin
        quo_reg      <= {quo_reg[30:0], div_ge};
        rem_reg      <= rem_next;
      end else if (state_reg == FIN) begin
        div_zero_reg <= is_div_reg & dz_reg;
      end
    end
  end

  assign div_zero = div_zero_reg;
`else
  always_comb begin
    fin_hi = mul_res[63:32];
    fin_lo = mul_res[31:0];
  end

  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      opnd_reg    <= '0;
      prod_reg    <= '0;
      neg_res_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          // A start always wins over a same-cycle MTHI/MTLO.
          if (accept_mul) begin
            state_reg   <= MUL;
            opnd_reg    <= rs_mag;
            prod_reg    <= {32'd0, rt_mag};
            neg_res_reg <= rs_neg ^ rt_neg;
          end
`ifdef MULDIV_DIV_EN
          else if (accept_div) begin
            state_reg   <= DIV;
            opnd_reg    <= rt_mag;
            neg_res_reg <= rs_neg ^ rt_neg;
          end
`endif
          else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        MUL: begin
          prod_reg <= {mul_sum, prod_reg[31:1]};
          cnt_reg  <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= FIN;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= FIN;
        end
`endif
        FIN: begin
          hi_reg    <= fin_hi;
          lo_reg    <= fin_lo;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;
endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Multi-cycle multiply/divide unit for the MIPS32 execute stage. It sits directly downstream of the single-cycle 32×32 multiplier, which only yields the low 32 bits. This unit computes full 64-bit MULT/MULTU products and DIV/DIVU quotient/remainder, and owns the architectural HI/LO registers. The pipeline stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface

- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs_val`  in  32  multiplicand / dividend
- `rt_val`  in  32  multiplier / divisor
- `mthi`  in  1  write `wdata` to HI (IDLE only)
- `mtlo`  in  1  write `wdata` to LO (IDLE only)
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress; pipeline stalls on it
- `done`  out  1  one-cycle pulse when HI/LO updated by an op
- `div_zero`  out  1  pulse with `done` when the divisor was 0
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation

- States: IDLE, MUL, DIV, FIN.
  - IDLE → MUL on `start` with op[1]=0.
  - IDLE → DIV on `start` with op[1]=1.
  - MUL/DIV → FIN after 32 iterations.
  - FIN → IDLE unconditionally.
- On start, latch operand magnitudes:
  - Signed ops (MULT, DIV): two's-complement absolute value.
  - Unsigned ops: raw values.
  - Also latch result-sign flags. Magnitude of 0x80000000 is 0x80000000 as unsigned.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 64-bit accumulator. In FIN, negate the product if operand signs differ (MULT only).
- DIV: restoring, one quotient bit per cycle, 33-bit partial remainder. In FIN, for DIV only:
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: still takes full latency. Result LO=0xFFFFFFFF, HI=rs_val (unmodified dividend), `div_zero`=1 with `done`.
- FIN writes HI=result[63:32] (remainder for DIV) and LO=result[31:0] (quotient for DIV).
- `start` while busy: ignored.
- `mthi`/`mtlo` while busy: ignored.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins; the moves are dropped.
- `mthi` and `mtlo` together: both registers take `wdata`.
- `busy` = (state != IDLE), registered.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter 0.
- Let E0 be the edge sampling `start` in IDLE.
  - `busy` is high after E0 through E33 (33 cycles).
  - Iterations occur at E1..E32.
  - FIN is active after E32. At E33, HI/LO are written, `done`=1, and state returns to IDLE.
  - `done` and `div_zero` are high exactly one cycle after E33.
  - Total latency: new HI/LO visible 33 cycles after E0.
- A new `start` is accepted at E34 at the earliest, i.e. while `done` is high.
- MTHI/MTLO: value visible the cycle after the sampling edge.
- `rst` mid-operation: all state and outputs return to reset values at that edge. No `done` is produced.

## Configuration

- `MULDIV_DIV_EN` defined:
  - Divider datapath, DIV state and `div_zero` logic are compiled in.
- Not defined:
  - `start` with op[1]=1 is ignored: no `busy`, no `done`, HI/LO unchanged.
  - `div_zero` is tied to 0.
  - MUL behaviour and timing are unchanged.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high 33 cycles. Then `done` pulse, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, `div_zero`=1 coincident with `done`.
- Start MULTU 5×6, then:
  - Assert `start` (op DIVU) and `mthi` at cycle 10 → both ignored.
  - Result HI=0, LO=30.
  - Then `mtlo` with `wdata`=0x1234 → LO=0x1234 next cycle.
- Start MULT and assert `rst` at cycle 10 → next cycle `busy`=0, HI=LO=0, no `done`. A subsequent MULTU 2×3 gives LO=6 after 33 cycles.
